// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a shared ALU: accepts one operation at a
// time, drives the ALU from registered operands and returns the result to its owner.
module alu_arbiter #(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [5:0]            req0_opcode,
  input  logic [5:0]            req1_opcode,
  input  logic [5:0]            req0_funct,
  input  logic [5:0]            req1_funct,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [5:0]            alu_opcode,
  output logic [5:0]            alu_funct,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic                  alu_en,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  localparam logic PRIO_INIT = RESET_PRIO[0];

  state_e                state_q;
  logic                  owner_q;
  logic                  prio_q;
  logic [1:0]            resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [5:0]            alu_opcode_q;
  logic [5:0]            alu_funct_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic                  alu_en_q;
  logic                  busy_q;

  logic                  grant_vld;
  logic                  grant_idx;
  logic [5:0]            sel_opcode;
  logic [5:0]            sel_funct;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    unique case (req_valid)
      2'b01:   begin grant_vld = 1'b1; grant_idx = 1'b0;   end
      2'b10:   begin grant_vld = 1'b1; grant_idx = 1'b1;   end
      2'b11:   begin grant_vld = 1'b1; grant_idx = prio_q; end
      default: begin grant_vld = 1'b0; grant_idx = 1'b0;   end
    endcase
  end

  assign sel_opcode = grant_idx ? req1_opcode : req0_opcode;
  assign sel_funct  = grant_idx ? req1_funct  : req0_funct;
  assign sel_a      = grant_idx ? req1_a      : req0_a;
  assign sel_b      = grant_idx ? req1_b      : req0_b;

  // Ready is only offered while idle and out of reset, so it always matches
  // the edge on which the FSM actually latches the operation.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state_q == ST_IDLE) && grant_vld) begin
      req_ready = grant_idx ? 2'b10 : 2'b01;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      prio_q       <= PRIO_INIT;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      alu_opcode_q <= '0;
      alu_funct_q  <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            alu_opcode_q <= sel_opcode;
            alu_funct_q  <= sel_funct;
            alu_a_q      <= sel_a;
            alu_b_q      <= sel_b;
            owner_q      <= grant_idx;
            alu_en_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_data_q  <= alu_result;
          resp_valid_q <= owner_q ? 2'b10 : 2'b01;
          alu_en_q     <= 1'b0;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's ready completes the transfer.
          if (resp_ready[owner_q]) begin
            resp_valid_q <= 2'b00;
            prio_q       <= ~owner_q;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 2'b00;
          alu_en_q     <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_funct  = alu_funct_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_en     = alu_en_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: per-port request drivers, a small MIPS ALU
// model, and a scoreboard monitor that checks every completed response.
module tb_alu_arbiter;

  localparam int DW = 32;

  typedef struct {
    logic [5:0]    opc;
    logic [5:0]    fn;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v0, v1;
  logic [1:0]    req_ready;
  logic [5:0]    req0_opcode, req1_opcode, req0_funct, req1_funct;
  logic [DW-1:0] req0_a, req1_a, req0_b, req1_b;
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [DW-1:0] resp_data;
  logic [5:0]    alu_opcode, alu_funct;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_en;
  logic          busy;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .RESET_PRIO(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   ({v1, v0}),
    .req_ready   (req_ready),
    .req0_opcode (req0_opcode),
    .req1_opcode (req1_opcode),
    .req0_funct  (req0_funct),
    .req1_funct  (req1_funct),
    .req0_a      (req0_a),
    .req1_a      (req1_a),
    .req0_b      (req0_b),
    .req1_b      (req1_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .alu_opcode  (alu_opcode),
    .alu_funct   (alu_funct),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_en      (alu_en),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // R-type subset: add, sub, and, or
  always_comb begin
    alu_result = '0;
    if (alu_opcode == 6'd0) begin
      case (alu_funct)
        6'd32:   alu_result = alu_a + alu_b;
        6'd34:   alu_result = alu_a - alu_b;
        6'd36:   alu_result = alu_a & alu_b;
        6'd37:   alu_result = alu_a | alu_b;
        default: alu_result = '0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester model: loads the next queued op when idle, holds it until accepted.
  task automatic drive_port(input int p);
    bit  acc = 1'b0;
    op_t op;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (p == 0) v0 = 1'b0; else v1 = 1'b0;
        acc = 1'b0;
      end else begin
        if (acc) begin
          if (p == 0) v0 = 1'b0; else v1 = 1'b0;
        end
        acc = 1'b0;
        if (p == 0 && !v0 && q0.size() != 0) begin
          op = q0.pop_front();
          req0_opcode = op.opc; req0_funct = op.fn; req0_a = op.a; req0_b = op.b;
          v0 = 1'b1;
        end else if (p == 1 && !v1 && q1.size() != 0) begin
          op = q1.pop_front();
          req1_opcode = op.opc; req1_funct = op.fn; req1_a = op.a; req1_b = op.b;
          v1 = 1'b1;
        end
      end
      #4;
      acc = rst_n && req_ready[p] && ((p == 0) ? v0 : v1);
    end
  endtask

  initial drive_port(0);
  initial drive_port(1);

  // Scoreboard monitor: samples just before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      check("req_ready_not_both", {31'd0, req_ready == 2'b11}, 32'd0);
      check("resp_valid_not_both", {31'd0, resp_valid == 2'b11}, 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (resp_valid[p] && resp_ready[p]) begin
          if (sb.size() == 0) begin
            check("unexpected_response_port", p, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("resp_port", p, e.port);
            check("resp_data", resp_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0 || v0 || v1 || busy) && n < 200) begin
      cyc();
      n++;
    end
    check({name, "_drain_in_budget"}, {31'd0, n < 200}, 32'd1);
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    resp_ready = 2'b11;
    v0 = 1'b0; v1 = 1'b0;
    req0_opcode = '0; req1_opcode = '0; req0_funct = '0; req1_funct = '0;
    req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;

    // Reset values
    cyc();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_en", alu_en, 32'd0);
    check("rst_busy", busy, 32'd0);
    rst_n = 1'b1;

    // Single request 5 + 7
    sb.push_back('{0, 32'd12});
    q0.push_back('{6'd0, 6'd32, 32'd5, 32'd7});
    cyc();
    check("t1_req_ready", req_ready, 2'b01);
    cyc();
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_alu_b", alu_b, 32'd7);
    check("t1_alu_funct", alu_funct, 32'd32);
    check("t1_alu_en", alu_en, 32'd1);
    check("t1_busy", busy, 32'd1);
    check("t1_req_ready_exec", req_ready, 2'b00);
    cyc();
    check("t1_resp_valid", resp_valid, 2'b01);
    check("t1_resp_data", resp_data, 32'd12);
    check("t1_alu_en_resp", alu_en, 32'd0);
    drain("t1");

    // Simultaneous requests right after reset: port 0 first
    do_reset();
    sb.push_back('{0, 32'd5});
    sb.push_back('{1, 32'hFF});
    q0.push_back('{6'd0, 6'd34, 32'd9, 32'd4});
    q1.push_back('{6'd0, 6'd37, 32'hF0, 32'h0F});
    cyc();
    check("t2_req_ready", req_ready, 2'b01);
    drain("t2");

    // Continuous contention: strict alternation 0,1,0,1,0,1
    sb.push_back('{0, 32'd3});
    sb.push_back('{1, 32'h11});
    sb.push_back('{0, 32'd99});
    sb.push_back('{1, 32'd0});
    sb.push_back('{0, 32'h0F00});
    sb.push_back('{1, 32'hFFFF_FFFF});
    q0.push_back('{6'd0, 6'd32, 32'd1, 32'd2});
    q0.push_back('{6'd0, 6'd34, 32'd100, 32'd1});
    q0.push_back('{6'd0, 6'd36, 32'hFF00, 32'h0FF0});
    q1.push_back('{6'd0, 6'd37, 32'h10, 32'h01});
    q1.push_back('{6'd0, 6'd32, 32'hFFFF_FFFF, 32'd1});
    q1.push_back('{6'd0, 6'd34, 32'd0, 32'd1});
    drain("t3");

    // Response back-pressure on port 0 with port 1 pending
    resp_ready = 2'b10;
    sb.push_back('{0, 32'd5});
    sb.push_back('{1, 32'hA5});
    q0.push_back('{6'd0, 6'd32, 32'd2, 32'd3});
    q1.push_back('{6'd0, 6'd37, 32'hA0, 32'h05});
    cyc();
    check("t4_req_ready", req_ready, 2'b01);
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t4_hold_resp_valid", resp_valid, 2'b01);
      check("t4_hold_resp_data", resp_data, 32'd5);
      check("t4_hold_busy", busy, 32'd1);
      check("t4_hold_req_ready", req_ready, 2'b00);
    end
    cyc();
    resp_ready = 2'b11;
    check("t4_req_ready_at_handshake", req_ready, 2'b00);
    cyc();
    check("t4_req_ready_after", req_ready, 2'b10);
    drain("t4");

    // Wrong-owner ready is ignored
    resp_ready = 2'b01;
    sb.push_back('{1, 32'd42});
    q1.push_back('{6'd0, 6'd34, 32'd50, 32'd8});
    cyc();
    check("t5_req_ready", req_ready, 2'b10);
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_resp_valid", resp_valid, 2'b10);
      check("t5_busy", busy, 32'd1);
      check("t5_resp_data", resp_data, 32'd42);
    end
    resp_ready = 2'b11;
    drain("t5");

    // Reset during EXEC: prio is 1 beforehand, must return to 0
    sb.push_back('{0, 32'd6});
    q0.push_back('{6'd0, 6'd32, 32'd3, 32'd3});
    drain("t6_pre");
    q1.push_back('{6'd0, 6'd32, 32'd1, 32'd1});
    cyc();
    check("t6_req_ready", req_ready, 2'b10);
    cyc();
    check("t6_exec_alu_en", alu_en, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_alu_en", alu_en, 32'd0);
    check("t6_rst_busy", busy, 32'd0);
    check("t6_rst_alu_a", alu_a, 32'd0);
    check("t6_rst_resp_data", resp_data, 32'd0);
    check("t6_rst_resp_valid", resp_valid, 2'b00);
    check("t6_rst_req_ready", req_ready, 2'b00);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t6_no_dropped_resp", resp_valid, 2'b00);
    end
    sb.push_back('{0, 32'hF000});
    sb.push_back('{1, 32'd30});
    q0.push_back('{6'd0, 6'd36, 32'hF0F0, 32'hFF00});
    q1.push_back('{6'd0, 6'd32, 32'd10, 32'd20});
    cyc();
    check("t6_prio_after_reset", req_ready, 2'b01);
    drain("t6");

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
